hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Produces the hazard_detected input consumed by the main decoder, and the
//  PC / IF-ID write-enable and flush strobes for the 5-stage pipeline (IF ID EX MEM WB).
//  Keeps a shadow record of the destination register of each instruction in EX and MEM.
//  Compares the ID-stage instruction against that record to insert load-use bubbles
//  (or full RAW bubbles when forwarding is absent). Also squashes the ID instruction
//  when EX resolves a taken branch.
// PARAMETERS
//  FORWARDING  1   1: stall only on load-use vs EX; 0: stall on any RAW vs EX or MEM
//  CNT_W       16  width of saturating data-stall performance counter
// PORTS
//  clk              in   1      pipeline clock, rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  id_valid         in   1      IF/ID register holds a real instruction
//  id_opcode        in   6      opcode of ID instruction
//  id_rs            in   5      rs field of ID instruction
//  id_rt            in   5      rt field of ID instruction
//  id_rd            in   5      rd field of ID instruction
//  ex_branch_taken  in   1      branch in EX resolved taken this cycle
//  hazard_detected  out  1      to decoder: force all control outputs to 0 (bubble)
//  pc_write         out  1      PC register load enable
//  if_id_write      out  1      IF/ID register load enable
//  if_id_flush      out  1      clear IF/ID register to a bubble next edge
//  stall_cycles     out  CNT_W  count of data-stall cycles, saturating
// BEHAVIOUR
//  Decode of the ID instruction (combinational):
//  - 000000 R-type: uses rs and rt; dest=rd.
//  - 100011 LW: uses rs; dest=rt; is_load=1.
//  - 001000 ADDI: uses rs; dest=rt.
//  - 101011 SW: uses rs and rt; no dest.
//  - 000100 BEQ: uses rs and rt; no dest.
//  - Other opcodes: use nothing; no dest.
//  - dest==0 is treated as no dest; $0 never causes a hazard.
//  State: two slots, ex_slot and mem_slot, each holding {valid, dest[4:0], is_load}.
//  Reset (async, rst_n=0): both slots invalid; stall_cycles=0.
//  Outputs then are hazard_detected=0, pc_write=1, if_id_write=1, if_id_flush=0.
//  raw_ex / raw_mem: the slot is valid, and its dest matches id_rs (when rs is used)
//  or id_rt (when rt is used).
//  data_stall (combinational, 0-cycle latency from the ID inputs):
//  - Always requires id_valid=1.
//  - FORWARDING=1: data_stall = raw_ex & ex_slot.is_load.
//  - FORWARDING=0: data_stall = raw_ex | raw_mem. The register file writes in the
//    first half of the cycle, so WB is not checked.
//  Output equations; flush has priority over stall:
//  - ex_branch_taken=1: hazard_detected=1, if_id_flush=1, pc_write=1, if_id_write=1.
//  - else data_stall=1: hazard_detected=1, pc_write=0, if_id_write=0, if_id_flush=0.
//  - else: hazard_detected=0, pc_write=1, if_id_write=1, if_id_flush=0.
//  Every clock edge:
//  - mem_slot <= ex_slot.
//  - ex_slot <= decoded ID if (id_valid & !hazard_detected); otherwise bubble (valid=0).
//  stall_cycles increments on each edge where data_stall=1 and ex_branch_taken=0.
//  - It holds at all-ones; it never wraps.
//  Flush-induced bubbles are not counted.
//  Stall lengths:
//  - FORWARDING=1: a load-use stall lasts exactly 1 cycle.
//  - FORWARDING=0: a stall lasts 2 cycles (producer in EX) or 1 cycle (producer in MEM).
//  Reset mid-stall: all slots are cleared immediately, and the pipeline resumes with no stall.
// TESTING
//  1. FWD=1: LW $t1 in ID, next cycle ADD $t2,$t1,$t3 in ID -> hazard_detected=1
//     and pc_write=0 for exactly 1 cycle; stall_cycles=1.
//  2. FWD=1: ADDI $t1 then ADD using $t1 -> no stall. FWD=0, same sequence -> 2 stall
//     cycles; stall_cycles=2.
//  3. LW $0,0($s0) then ADD $t2,$0,$0 -> no stall under either parameter value.
//  4. Load-use stall pending and ex_branch_taken=1 in the same cycle -> if_id_flush=1,
//     pc_write=1, no count increment; the next cycle shows no stall.
//  5. SW/BEQ followed by a consumer of rt -> no stall (no dest). An unknown opcode
//     in ID -> never stalls.
//  6. Force CNT_W=4, run 20 load-use pairs -> stall_cycles holds at 15.
//     Pulse rst_n low mid-stall -> count=0, outputs return to their reset values
//     asynchronously.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline (IF ID EX MEM WB).
// Tracks the destination registers of the instructions in EX and MEM.
// Stalls the ID instruction on data hazards and flushes it on a taken branch.
// Also keeps a saturating count of data-stall cycles.
module hazard_unit #(
   parameter int FORWARDING = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             ex_branch_taken,
   output logic             hazard_detected,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // One in-flight producer: valid only when it really writes a non-zero register.
   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       is_load;
   } slot_t;

   slot_t            ex_slot_q,      ex_slot_d;
   slot_t            mem_slot_q,     mem_slot_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic       uses_rs;
   logic       uses_rt;
   logic [4:0] dec_dest;
   logic       dec_load;
   logic       raw_ex;
   logic       raw_mem;
   logic       data_stall;

   // Decode which source fields the ID instruction reads and what it writes.
   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      uses_rs  = 1'b0;
      uses_rt  = 1'b0;
      dec_dest = 5'd0;
      dec_load = 1'b0;
      case (id_opcode)
         OP_RTYPE: begin
            uses_rs  = 1'b1;
            uses_rt  = 1'b1;
            dec_dest = id_rd;
         end
         OP_LW: begin
            uses_rs  = 1'b1;
            dec_dest = id_rt;
            dec_load = 1'b1;
         end
         OP_ADDI: begin
            uses_rs  = 1'b1;
            dec_dest = id_rt;
         end
         OP_SW, OP_BEQ: begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         default: ;
      endcase
   end

   // Compare ID sources against the shadow record; $0 never lands in a valid slot.
   always_comb begin
      raw_ex  = ex_slot_q.valid &
                ((uses_rs && (ex_slot_q.dest == id_rs)) ||
                 (uses_rt && (ex_slot_q.dest == id_rt)));
      raw_mem = mem_slot_q.valid &
                ((uses_rs && (mem_slot_q.dest == id_rs)) ||
                 (uses_rt && (mem_slot_q.dest == id_rt)));
      if (FORWARDING != 0) begin
         data_stall = id_valid & raw_ex & ex_slot_q.is_load;
      end else begin
         // Register file writes in the first half-cycle, so WB needs no check.
         data_stall = id_valid & (raw_ex | raw_mem);
      end
   end

   // Pipeline control strobes; a taken branch outranks a data stall.
   always_comb begin
      hazard_detected = 1'b0;
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      if_id_flush     = 1'b0;
      if (ex_branch_taken) begin
         hazard_detected = 1'b1;
         if_id_flush     = 1'b1;
      end else if (data_stall) begin
         hazard_detected = 1'b1;
         pc_write        = 1'b0;
         if_id_write     = 1'b0;
      end
   end

   // Next-state: shift the record, inject a bubble when ID does not advance, count stalls.
   always_comb begin
      mem_slot_d     = ex_slot_q;
      ex_slot_d      = '0;
      stall_cycles_d = stall_cycles_q;
      if (id_valid && !hazard_detected && (dec_dest != 5'd0)) begin
         ex_slot_d.valid   = 1'b1;
         ex_slot_d.dest    = dec_dest;
         ex_slot_d.is_load = dec_load;
      end
      if (data_stall && !ex_branch_taken && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   // State registers.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_slot_q      <= '0;
         mem_slot_q     <= '0;
         stall_cycles_q <= '0;
      end else begin
         ex_slot_q      <= ex_slot_d;
         mem_slot_q     <= mem_slot_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (FORWARDING=1, FORWARDING=0, FORWARDING=1 with CNT_W=4)
// share one stimulus stream; each is checked against an instruction-level model.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0;
   logic [5:0] id_opcode = '0;
   logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic       ex_branch_taken = 1'b0;

   logic [2:0]  hz_w, pcw_w, ifw_w, fl_w;
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_unit #(.FORWARDING(1), .CNT_W(16)) dut_f1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
      .hazard_detected(hz_w[0]), .pc_write(pcw_w[0]), .if_id_write(ifw_w[0]),
      .if_id_flush(fl_w[0]), .stall_cycles(cnt0));

   hazard_unit #(.FORWARDING(0), .CNT_W(16)) dut_f0 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
      .hazard_detected(hz_w[1]), .pc_write(pcw_w[1]), .if_id_write(ifw_w[1]),
      .if_id_flush(fl_w[1]), .stall_cycles(cnt1));

   hazard_unit #(.FORWARDING(1), .CNT_W(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
      .hazard_detected(hz_w[2]), .pc_write(pcw_w[2]), .if_id_write(ifw_w[2]),
      .if_id_flush(fl_w[2]), .stall_cycles(cnt2));

   // ---------------- reference model ----------------
   // Each variant remembers the register written by the instruction that entered EX
   // last cycle (ex_dst) and the one before that (mem_dst); -1 means "nothing useful".
   int m_ex_dst[3], m_mem_dst[3], m_cnt[3];
   bit m_ex_ld[3];

   function automatic bit fwd_of(int v);
      return (v != 1);
   endfunction

   function automatic int cmax_of(int v);
      return (v == 2) ? 15 : 65535;
   endfunction

   task automatic decode(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                         output bit urs, output bit urt, output int dst, output bit ld);
      urs = 0; urt = 0; dst = -1; ld = 0;
      if (op == 6'd0)        begin urs = 1; urt = 1; dst = rd; end
      else if (op == 6'h23)  begin urs = 1; dst = rt; ld = 1; end
      else if (op == 6'h08)  begin urs = 1; dst = rt; end
      else if (op == 6'h2B || op == 6'h04) begin urs = 1; urt = 1; end
      if (dst == 0) dst = -1;
   endtask

   task automatic model_eval(input int v, output bit hz, output bit pcw, output bit fl,
                             output bit ds);
      bit urs, urt, ld, hit_ex, hit_mem;
      int dst;
      decode(id_opcode, id_rs, id_rt, id_rd, urs, urt, dst, ld);
      hit_ex  = (m_ex_dst[v] >= 0) &&
                ((urs && int'(id_rs) == m_ex_dst[v]) || (urt && int'(id_rt) == m_ex_dst[v]));
      hit_mem = (m_mem_dst[v] >= 0) &&
                ((urs && int'(id_rs) == m_mem_dst[v]) || (urt && int'(id_rt) == m_mem_dst[v]));
      if (fwd_of(v)) ds = id_valid && hit_ex && m_ex_ld[v];
      else           ds = id_valid && (hit_ex || hit_mem);
      fl  = ex_branch_taken;
      hz  = ex_branch_taken || ds;
      pcw = ex_branch_taken || !ds;
   endtask

   task automatic model_reset();
      for (int v = 0; v < 3; v++) begin
         m_ex_dst[v] = -1; m_mem_dst[v] = -1; m_ex_ld[v] = 0; m_cnt[v] = 0;
      end
   endtask

   function automatic int cnt_of(int v);
      if (v == 0) return int'(cnt0);
      if (v == 1) return int'(cnt1);
      return int'(cnt2);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      bit hz, pcw, fl, ds;
      for (int v = 0; v < 3; v++) begin
         model_eval(v, hz, pcw, fl, ds);
         check($sformatf("hazard_v%0d", v), int'(hz_w[v]), int'(hz));
         check($sformatf("pc_write_v%0d", v), int'(pcw_w[v]), int'(pcw));
         check($sformatf("if_id_write_v%0d", v), int'(ifw_w[v]), int'(pcw));
         check($sformatf("flush_v%0d", v), int'(fl_w[v]), int'(fl));
         check($sformatf("count_v%0d", v), cnt_of(v), m_cnt[v]);
      end
   endtask

   task automatic apply(input logic vld, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                        input logic br);
      @(negedge clk);
      id_valid = vld; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
      ex_branch_taken = br;
      #1;
      check_model();
   endtask

   // Advance the model across one clock edge using the inputs currently applied.
   task automatic step();
      int  n_ex[3], n_mem[3], n_cnt[3];
      bit  n_ld[3];
      bit  hz, pcw, fl, ds, urs, urt, ld;
      int  dst;
      decode(id_opcode, id_rs, id_rt, id_rd, urs, urt, dst, ld);
      for (int v = 0; v < 3; v++) begin
         model_eval(v, hz, pcw, fl, ds);
         n_mem[v] = m_ex_dst[v];
         n_ex[v]  = (id_valid && !hz) ? dst : -1;
         n_ld[v]  = (id_valid && !hz) ? ld : 1'b0;
         n_cnt[v] = (ds && !ex_branch_taken && m_cnt[v] < cmax_of(v)) ? m_cnt[v] + 1 : m_cnt[v];
      end
      @(posedge clk);
      for (int v = 0; v < 3; v++) begin
         m_ex_dst[v] = n_ex[v]; m_mem_dst[v] = n_mem[v];
         m_ex_ld[v] = n_ld[v]; m_cnt[v] = n_cnt[v];
      end
   endtask

   task automatic cyc(input logic vld, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                      input logic br);
      apply(vld, op, rs, rt, rd, br);
      step();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic       vld;
      logic [5:0] op;
      logic [4:0] rs, rt, rd;
      logic       br;
      logic       hz_f1;   // expected hazard_detected with forwarding
      logic       hz_f0;   // expected hazard_detected without forwarding
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic vld, logic [5:0] op, logic [4:0] rs, rt, rd, logic br,
                               logic h1, logic h0);
      vec_t r;
      r.vld = vld; r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.br = br;
      r.hz_f1 = h1; r.hz_f0 = h0;
      return r;
   endfunction

   initial begin
      bit exp_pcw;
      // $t1=9 $t2=10 $t3=11 $s0=16
      // load-use: LW $t1 then ADD $t2,$t1,$t3 held in ID while stalled
      tbl.push_back(mk(1, 6'h23, 16,  9,  0, 0, 0, 0));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 0, 1, 1));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 0, 0, 1));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      // ALU producer: ADDI $t1 then ADD using $t1
      tbl.push_back(mk(1, 6'h08, 16,  9,  0, 0, 0, 0));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 0, 0, 1));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 0, 0, 1));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      // $0 destination never hazards
      tbl.push_back(mk(1, 6'h23, 16,  0,  0, 0, 0, 0));
      tbl.push_back(mk(1, 6'h00,  0,  0, 10, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      // SW/BEQ have no destination; unknown opcode reads nothing
      tbl.push_back(mk(1, 6'h2B, 16,  9,  0, 0, 0, 0));
      tbl.push_back(mk(1, 6'h00, 11,  9, 10, 0, 0, 0));
      tbl.push_back(mk(1, 6'h04,  9,  9,  0, 0, 0, 0));
      tbl.push_back(mk(1, 6'h00,  9, 11, 12, 0, 0, 0));
      tbl.push_back(mk(1, 6'h3F, 12, 12, 12, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      // branch taken while load-use pending: flush wins, no count
      tbl.push_back(mk(1, 6'h23, 16,  9,  0, 0, 0, 0));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 1, 1, 1));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 0, 0, 1));
      tbl.push_back(mk(1, 6'h00,  9, 11, 10, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 6'h00,  0,  0,  0, 0, 0, 0));

      model_reset();
      // reset state
      repeat (2) @(posedge clk);
      #1;
      for (int v = 0; v < 3; v++) begin
         check($sformatf("rst_hazard_v%0d", v), int'(hz_w[v]), 0);
         check($sformatf("rst_pc_write_v%0d", v), int'(pcw_w[v]), 1);
         check($sformatf("rst_if_id_write_v%0d", v), int'(ifw_w[v]), 1);
         check($sformatf("rst_flush_v%0d", v), int'(fl_w[v]), 0);
         check($sformatf("rst_count_v%0d", v), cnt_of(v), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven directed vectors
      foreach (tbl[i]) begin
         apply(tbl[i].vld, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].br);
         check($sformatf("tbl%0d_hazard_f1", i), int'(hz_w[0]), int'(tbl[i].hz_f1));
         check($sformatf("tbl%0d_hazard_f0", i), int'(hz_w[1]), int'(tbl[i].hz_f0));
         check($sformatf("tbl%0d_flush", i), int'(fl_w[0]), int'(tbl[i].br));
         exp_pcw = tbl[i].br || !tbl[i].hz_f0;
         check($sformatf("tbl%0d_pc_write_f0", i), int'(pcw_w[1]), int'(exp_pcw));
         step();
      end
      // one load-use stall with forwarding; 2+2+1 data stalls without
      check("tbl_count_f1", int'(cnt0), 1);
      check("tbl_count_f0", int'(cnt1), 5);
      check("tbl_count_c4", int'(cnt2), 1);

      // randomized traffic over a small register set to provoke hazards
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op;
         case ($urandom_range(0, 6))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h08;
            3: op = 6'h2B;
            4: op = 6'h04;
            5: op = 6'h23;
            default: op = 6'($urandom);
         endcase
         cyc(($urandom_range(0, 9) != 0), op, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 11) == 0));
      end

      // saturation: fresh reset, then 20 load-use pairs
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int p = 0; p < 20; p++) begin
         cyc(1, 6'h23, 16, 9, 0, 0);
         cyc(1, 6'h00, 9, 11, 10, 0);
         cyc(1, 6'h00, 9, 11, 10, 0);
         cyc(0, 6'h00, 0, 0, 0, 0);
         cyc(0, 6'h00, 0, 0, 0, 0);
      end
      check("sat_count_c4", int'(cnt2), 15);
      check("sat_count_f1", int'(cnt0), 20);
      check("sat_count_f0", int'(cnt1), 40);

      // asynchronous reset in the middle of a load-use stall
      cyc(1, 6'h23, 16, 9, 0, 0);
      apply(1, 6'h00, 9, 11, 10, 0);
      check("pre_rst_stall_f1", int'(hz_w[0]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int v = 0; v < 3; v++) begin
         check($sformatf("mid_rst_hazard_v%0d", v), int'(hz_w[v]), 0);
         check($sformatf("mid_rst_pc_write_v%0d", v), int'(pcw_w[v]), 1);
         check($sformatf("mid_rst_if_id_write_v%0d", v), int'(ifw_w[v]), 1);
         check($sformatf("mid_rst_flush_v%0d", v), int'(fl_w[v]), 0);
         check($sformatf("mid_rst_count_v%0d", v), cnt_of(v), 0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      apply(1, 6'h00, 9, 11, 10, 0);
      check("post_rst_no_stall_f1", int'(hz_w[0]), 0);
      check("post_rst_no_stall_f0", int'(hz_w[1]), 0);
      step();
      cyc(0, 6'h00, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
